// File: rtl/iob_axi_ram_resp.sv
`default_nettype none
// ============================================================================
// Module   : iob_axi_ram_resp
// Brief    : AXI4 subordinate answering INCR/FIXED bursts from a single-port
//            synchronous RAM, one transaction in flight. Optional macro
//            IOB_AXI_RAM_RESP_BOUNDS_EN flags beats beyond MEM_WORDS (SLVERR).
// Revision : 1.0 - initial release
// ============================================================================
module iob_axi_ram_resp #(
    parameter int ID_W       = 1,
    parameter int LEN_W      = 4,
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 12,
    parameter int MEM_WORDS  = 3072
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,

    input  logic [ID_W-1:0]       axi_awid_i,
    input  logic [ADDR_W-1:0]     axi_awaddr_i,
    input  logic [LEN_W-1:0]      axi_awlen_i,
    input  logic [1:0]            axi_awburst_i,
    input  logic                  axi_awvalid_i,
    output logic                  axi_awready_o,

    input  logic [DATA_W-1:0]     axi_wdata_i,
    input  logic [DATA_W/8-1:0]   axi_wstrb_i,
    input  logic                  axi_wlast_i,
    input  logic                  axi_wvalid_i,
    output logic                  axi_wready_o,

    output logic [ID_W-1:0]       axi_bid_o,
    output logic [1:0]            axi_bresp_o,
    output logic                  axi_bvalid_o,
    input  logic                  axi_bready_i,

    input  logic [ID_W-1:0]       axi_arid_i,
    input  logic [ADDR_W-1:0]     axi_araddr_i,
    input  logic [LEN_W-1:0]      axi_arlen_i,
    input  logic [1:0]            axi_arburst_i,
    input  logic                  axi_arvalid_i,
    output logic                  axi_arready_o,

    output logic [ID_W-1:0]       axi_rid_o,
    output logic [DATA_W-1:0]     axi_rdata_o,
    output logic [1:0]            axi_rresp_o,
    output logic                  axi_rlast_o,
    output logic                  axi_rvalid_o,
    input  logic                  axi_rready_i,

    output logic                  ram_en_o,
    output logic [DATA_W/8-1:0]   ram_we_o,
    output logic [MEM_ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0]     ram_d_o,
    input  logic [DATA_W-1:0]     ram_d_i
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int OFFS_W  = $clog2(STRB_W);
    localparam int LIMIT_W = MEM_ADDR_W + 1;
    localparam logic [LIMIT_W-1:0] MEM_LIMIT = LIMIT_W'(MEM_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [ID_W-1:0]       id_q;
    logic [MEM_ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt_q;
    logic                  fixed_q;
    logic                  last_wr_q;

    logic [ADDR_W-1:0]     aw_word;
    logic [ADDR_W-1:0]     ar_word;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  aw_hs;
    logic                  ar_hs;
    logic                  w_hs;
    logic                  r_hs;
    logic                  beat_last;
    logic                  oor;
    logic [MEM_ADDR_W-1:0] addr_step;

    assign aw_word = axi_awaddr_i >> OFFS_W;
    assign ar_word = axi_araddr_i >> OFFS_W;

    // On a tie the channel that lost last time wins; last_wr_q resets to "read".
    assign grant_wr = axi_awvalid_i && (!axi_arvalid_i || !last_wr_q);
    assign grant_rd = axi_arvalid_i && !grant_wr;

    assign aw_hs     = (state == IDLE) && grant_wr;
    assign ar_hs     = (state == IDLE) && grant_rd;
    assign w_hs      = (state == WR_DATA) && axi_wvalid_i;
    assign r_hs      = (state == RD_DATA) && axi_rready_i;
    assign beat_last = (cnt_q == len_q);
    assign addr_step = fixed_q ? addr_q : addr_q + MEM_ADDR_W'(1);

`ifdef IOB_AXI_RAM_RESP_BOUNDS_EN
    logic wr_err_q;

    assign oor = ({1'b0, addr_q} >= MEM_LIMIT);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_err_q <= 1'b0;
        end else if (aw_hs) begin
            wr_err_q <= 1'b0;
        end else if (w_hs && oor) begin
            wr_err_q <= 1'b1;
        end
    end

    assign axi_bresp_o = wr_err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_rresp_o = ((state == RD_DATA) && oor) ? RESP_SLVERR : RESP_OKAY;
    assign axi_rdata_o = oor ? '0 : ram_d_i;
`else
    assign oor         = 1'b0;
    assign axi_bresp_o = RESP_OKAY;
    assign axi_rresp_o = RESP_OKAY;
    assign axi_rdata_o = ram_d_i;
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        axi_awready_o = 1'b0;
        axi_arready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_bvalid_o  = 1'b0;
        axi_rvalid_o  = 1'b0;
        axi_rlast_o   = 1'b0;
        ram_en_o      = 1'b0;
        ram_we_o      = '0;
        case (state)
            IDLE: begin
                axi_awready_o = grant_wr;
                axi_arready_o = grant_rd;
                if (grant_wr) begin
                    state_nxt = WR_DATA;
                end else if (grant_rd) begin
                    state_nxt = RD_ADDR;
                end
            end
            WR_DATA: begin
                axi_wready_o = 1'b1;
                if (axi_wvalid_i) begin
                    ram_en_o = !oor;
                    ram_we_o = oor ? '0 : axi_wstrb_i;
                    // wlast is not consulted: the beat counter alone ends the burst
                    if (beat_last) begin
                        state_nxt = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                axi_bvalid_o = 1'b1;
                if (axi_bready_i) begin
                    state_nxt = IDLE;
                end
            end
            RD_ADDR: begin
                ram_en_o  = !oor;
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                // RAM output is held while ram_en_o is low, so rdata is stable here
                axi_rvalid_o = 1'b1;
                axi_rlast_o  = beat_last;
                if (axi_rready_i) begin
                    state_nxt = beat_last ? IDLE : RD_ADDR;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            fixed_q   <= 1'b0;
            last_wr_q <= 1'b0;
        end else if (aw_hs) begin
            id_q      <= axi_awid_i;
            addr_q    <= aw_word[MEM_ADDR_W-1:0];
            len_q     <= axi_awlen_i;
            cnt_q     <= '0;
            fixed_q   <= (axi_awburst_i == 2'b00);
            last_wr_q <= 1'b1;
        end else if (ar_hs) begin
            id_q      <= axi_arid_i;
            addr_q    <= ar_word[MEM_ADDR_W-1:0];
            len_q     <= axi_arlen_i;
            cnt_q     <= '0;
            fixed_q   <= (axi_arburst_i == 2'b00);
            last_wr_q <= 1'b0;
        end else if (w_hs || r_hs) begin
            cnt_q  <= cnt_q + LEN_W'(1);
            addr_q <= addr_step;
        end
    end

    assign axi_bid_o  = id_q;
    assign axi_rid_o  = id_q;
    assign ram_addr_o = addr_q;
    assign ram_d_o    = axi_wdata_i;

    logic unused_bits;
    assign unused_bits = ^{axi_wlast_i, axi_awaddr_i, axi_araddr_i, aw_word, ar_word, MEM_LIMIT};

endmodule
`default_nettype wire

// File: tb/tb_iob_axi_ram_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_axi_ram_resp
// Brief    : Scoreboard bench for iob_axi_ram_resp: randomized bursts against a
//            word-array reference memory; responses checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_axi_ram_resp;

    localparam int ID_W = 1, LEN_W = 4, ADDR_W = 24, DATA_W = 32, STRB_W = 4;
    localparam int MEM_ADDR_W = 12, MEM_WORDS = 3072, DEPTH = 4096;
`ifdef IOB_AXI_RAM_RESP_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ID_W-1:0]       awid, arid, bid, rid;
    logic [ADDR_W-1:0]     awaddr, araddr;
    logic [LEN_W-1:0]      awlen, arlen;
    logic [1:0]            awburst, arburst, bresp, rresp;
    logic                  awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic                  arvalid, arready, rvalid, rready, rlast;
    logic [DATA_W-1:0]     wdata, rdata, ram_d, ram_q;
    logic [STRB_W-1:0]     wstrb, ram_we;
    logic                  ram_en;
    logic [MEM_ADDR_W-1:0] ram_addr;

    iob_axi_ram_resp dut (
        .clk_i(clk), .arst_n_i(rst_n),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awburst_i(awburst),
        .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arburst_i(arburst),
        .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_d_o(ram_d),
        .ram_d_i(ram_q)
    );

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) + 32'h1234_5678;
    endfunction

    // Single-port synchronous RAM attached to the DUT (read-first, output held when idle)
    logic [DATA_W-1:0] ram [DEPTH];
    logic ram_fill;
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
        end else if (ram_en) begin
            for (int b = 0; b < STRB_W; b++)
                if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
            ram_q <= ram[ram_addr];
        end
    end

    typedef struct packed {logic [ID_W-1:0] id; logic [1:0] resp;} b_exp_t;
    typedef struct packed {logic [ID_W-1:0] id; logic [DATA_W-1:0] data; logic [1:0] resp; logic last;} r_exp_t;
    b_exp_t bq[$];
    r_exp_t rq[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] wd [16];
    logic [STRB_W-1:0] ws [16];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
        end
    endtask

    function automatic bit in_range(input int w);
        return !BOUNDS || (w < MEM_WORDS);
    endfunction

    always @(negedge clk) begin
        b_exp_t be;
        r_exp_t re;
        if (rst_n) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL b_unexpected: got bresp=%0d, want no response", bresp);
                end else begin
                    be = bq.pop_front();
                    check("b_id", 32'(bid), 32'(be.id));
                    check("b_resp", 32'(bresp), 32'(be.resp));
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL r_unexpected: got rdata=0x%0h, want no beat", rdata);
                end else begin
                    re = rq.pop_front();
                    check("r_id", 32'(rid), 32'(re.id));
                    check("r_data", rdata, re.data);
                    check("r_resp", 32'(rresp), 32'(re.resp));
                    check("r_last", 32'(rlast), 32'(re.last));
                end
            end
        end
    end

    task automatic wr_txn(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input int len, input logic [1:0] burst, input bit pre);
        int w, to;
        bit err;
        if (!pre) begin
            awid = id; awaddr = addr; awlen = 4'(len); awburst = burst; awvalid = 1'b1;
            to = 0;
            do begin @(negedge clk); to++; end while (!awready && to < 64);
            check("aw_accept", 32'(awready), 1);
            @(posedge clk); #1;
            awvalid = 1'b0;
        end
        w = (int'(addr) >> 2) % DEPTH;
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clk); #1;
            end
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == len);
            @(negedge clk);
            check("wready", 32'(wready), 1);
            check("ram_en_w", 32'(ram_en), 32'(in_range(w)));
            if (in_range(w)) begin
                check("ram_addr_w", 32'(ram_addr), 32'(w));
                check("ram_we_w", 32'(ram_we), 32'(ws[i]));
                for (int b = 0; b < STRB_W; b++)
                    if (ws[i][b]) ref_mem[w][8*b +: 8] = wd[i][8*b +: 8];
            end else begin
                err = 1'b1;
            end
            @(posedge clk); #1;
            if (burst != 2'b00) w = (w + 1) % DEPTH;
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        check("bvalid_timing", 32'(bvalid), 1);
        to = $urandom_range(0, 3);
        for (int k = 0; k < to; k++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(bvalid), 1);
        end
        bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        @(posedge clk); #1;
        bready = 1'b1;
        to = 0;
        do begin @(negedge clk); to++; end while (!bvalid && to < 64);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic rd_txn(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input int len, input logic [1:0] burst,
                          input int bp_beat, input int bp_cycles, input bit pre);
        int w, to;
        logic [DATA_W-1:0] exp_d;
        if (!pre) begin
            arid = id; araddr = addr; arlen = 4'(len); arburst = burst; arvalid = 1'b1;
            to = 0;
            do begin @(negedge clk); to++; end while (!arready && to < 64);
            check("ar_accept", 32'(arready), 1);
            @(posedge clk); #1;
            arvalid = 1'b0;
        end
        w = (int'(addr) >> 2) % DEPTH;
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            check("rvalid_early", 32'(rvalid), 0);
            check("ram_en_r", 32'(ram_en), 32'(in_range(w)));
            check("ram_we_r", 32'(ram_we), 0);
            if (in_range(w)) check("ram_addr_r", 32'(ram_addr), 32'(w));
            @(negedge clk);
            check("rvalid_latency", 32'(rvalid), 1);
            to = 0;
            while (!rvalid && to < 32) begin @(negedge clk); to++; end
            exp_d = in_range(w) ? ref_mem[w] : '0;
            if (i == bp_beat) begin
                for (int k = 0; k < bp_cycles; k++) begin
                    @(negedge clk);
                    check("bp_rvalid", 32'(rvalid), 1);
                    check("bp_rdata", rdata, exp_d);
                    check("bp_no_ram", 32'(ram_en), 0);
                end
            end
            rq.push_back('{id: id, data: exp_d, resp: in_range(w) ? 2'b00 : 2'b10, last: (i == len)});
            @(posedge clk); #1;
            rready = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            rready = 1'b0;
            if (burst != 2'b00) w = (w + 1) % DEPTH;
        end
    endtask

    task automatic tie(input bit exp_wr);
        int lw, lr;
        lw = $urandom_range(0, 3);
        lr = $urandom_range(0, 3);
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        awid = 1'($urandom); awaddr = 24'($urandom); awlen = 4'(lw); awburst = 2'b01;
        arid = 1'($urandom); araddr = 24'($urandom); arlen = 4'(lr); arburst = 2'b01;
        awvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        check("tie_awready", 32'(awready), 32'(exp_wr));
        check("tie_arready", 32'(arready), 32'(!exp_wr));
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        if (exp_wr) wr_txn(awid, awaddr, lw, 2'b01, 1'b1);
        else        rd_txn(arid, araddr, lr, 2'b01, -1, 0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1);
    end

    initial begin
        int len, to;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        ram_fill = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        repeat (2) @(posedge clk);
        #1 ram_fill = 1'b0;
        @(negedge clk);
        check("rst_awready", 32'(awready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_ram_en", 32'(ram_en), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_rlast", 32'(rlast), 0);
        check("rst_bresp", 32'(bresp), 0);
        check("rst_rresp", 32'(rresp), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write then read back
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        wr_txn(1'b1, 24'h10, 0, 2'b01, 1'b0);
        rd_txn(1'b1, 24'h10, 0, 2'b01, -1, 0, 1'b0);

        // 16-beat INCR with a partial strobe on beat 5, read with backpressure on beat 2
        for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
        ws[5] = 4'h3;
        wr_txn(1'b0, 24'h100, 15, 2'b01, 1'b0);
        rd_txn(1'b0, 24'h100, 15, 2'b01, 2, 5, 1'b0);

        // FIXED write of 4 beats to 0x40 then read of that word
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        wr_txn(1'b1, 24'h40, 3, 2'b00, 1'b0);
        rd_txn(1'b1, 24'h40, 0, 2'b01, -1, 0, 1'b0);

        // Read across the MEM_WORDS edge, and a write wrapping the word address
        rd_txn(1'b0, 24'(3071 * 4), 1, 2'b01, -1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'(i + 12); end
        wr_txn(1'b0, 24'(4094 * 4), 3, 2'b01, 1'b0);
        rd_txn(1'b0, 24'(4094 * 4), 3, 2'b10, -1, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                wr_txn(1'($urandom), 24'($urandom), len, 2'($urandom_range(0, 2)), 1'b0);
            end else begin
                rd_txn(1'($urandom), 24'($urandom), len, 2'($urandom_range(0, 2)),
                       $urandom_range(0, len), $urandom_range(0, 3), 1'b0);
            end
        end

        // Reset asserted mid-read aborts with no response
        arid = 1'b1; araddr = 24'h200; arlen = 4'd7; arburst = 2'b01; arvalid = 1'b1;
        to = 0;
        do begin @(negedge clk); to++; end while (!arready && to < 64);
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rvalid", 32'(rvalid), 0);
        check("abort_ram_en", 32'(ram_en), 0);
        check("abort_awready", 32'(awready), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Ties after reset: write first, then alternate
        tie(1'b1);
        tie(1'b0);
        tie(1'b1);
        tie(1'b0);

        repeat (4) @(posedge clk);
        check("b_queue_empty", 32'(bq.size()), 0);
        check("r_queue_empty", 32'(rq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iob_axi_ram_resp.md
# iob_axi_ram_resp

AXI4 subordinate that answers the SoC's external-memory AXI master port with a single-port synchronous RAM, replacing the DDR3 controller in simulation and in small-FPGA builds. It accepts INCR and FIXED bursts on the AW/W/B and AR/R channels and turns each beat into one native RAM access. It keeps one transaction in flight at a time.

## Interface
Parameters:
- `ID_W`, default 1: AXI ID width.
- `LEN_W`, default 4: AXI burst length width; bursts of up to 16 beats.
- `ADDR_W`, default 24: AXI byte address width.
- `DATA_W`, default 32: data width; `STRB_W = DATA_W/8`.
- `MEM_ADDR_W`, default 12: RAM word address width.
- `MEM_WORDS`, default 3072: number of populated RAM words; must be ≤ 2^`MEM_ADDR_W`.

Ports (name, direction, width, meaning):
- `clk_i`, in, 1: clock, single domain.
- `arst_n_i`, in, 1: reset, asynchronous, active-low.
- `axi_awid_i`/`axi_awaddr_i`/`axi_awlen_i`/`axi_awburst_i`, in, ID_W/ADDR_W/LEN_W/2: write address.
- `axi_awvalid_i`, in, 1 / `axi_awready_o`, out, 1: write address handshake.
- `axi_wdata_i`/`axi_wstrb_i`/`axi_wlast_i`, in, DATA_W/STRB_W/1: write data.
- `axi_wvalid_i`, in, 1 / `axi_wready_o`, out, 1: write data handshake.
- `axi_bid_o`/`axi_bresp_o`, out, ID_W/2: write response.
- `axi_bvalid_o`, out, 1 / `axi_bready_i`, in, 1: write response handshake.
- `axi_arid_i`/`axi_araddr_i`/`axi_arlen_i`/`axi_arburst_i`, in, ID_W/ADDR_W/LEN_W/2: read address.
- `axi_arvalid_i`, in, 1 / `axi_arready_o`, out, 1: read address handshake.
- `axi_rid_o`/`axi_rdata_o`/`axi_rresp_o`/`axi_rlast_o`, out, ID_W/DATA_W/2/1: read data.
- `axi_rvalid_o`, out, 1 / `axi_rready_i`, in, 1: read data handshake.
- `ram_en_o`, out, 1 / `ram_we_o`, out, STRB_W / `ram_addr_o`, out, MEM_ADDR_W / `ram_d_o`, out, DATA_W: RAM port.
- `ram_d_i`, in, DATA_W: RAM read data. Valid one cycle after the access. Held while `ram_en_o`=0.

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA. Reset state is IDLE.
- IDLE: `axi_awready_o`/`axi_arready_o` follow the arbiter combinationally. Only the granted channel is ready.
- Arbiter: if only one valid is high, that channel wins. If both are high, the channel *not* granted last time wins. The last-grant flag resets to "read", so the first tie goes to write.
- On AW handshake: latch ID, word address `awaddr[ADDR_W-1:log2(STRB_W)]`, and len. Clear the beat counter. Go to WR_DATA.
- WR_DATA: `axi_wready_o`=1. Each W handshake drives `ram_en_o`=1, `ram_we_o`=`wstrb`, and `ram_d_o`=`wdata` in the same cycle, combinationally.
- The burst ends when beat count equals len. `wlast` is ignored; the counter alone terminates the burst. Then go to WR_RESP.
- WR_RESP: `axi_bvalid_o`=1 with the latched ID. Hold until `bready`, then go to IDLE.
- On AR handshake: latch ID, word address, and len. Go to RD_ADDR.
- RD_ADDR: `ram_en_o`=1, `ram_we_o`=0 for one cycle. Go to RD_DATA.
- RD_DATA: `axi_rvalid_o`=1, `axi_rdata_o`=`ram_d_i`, `axi_rlast_o`=(count==len).
  - On `rready` with not-last: increment the address and go to RD_ADDR.
  - On `rready` with last: go to IDLE.
- Address update per beat: INCR (01) and WRAP (10) add 1 word. FIXED (00) keeps the address. Any `axsize` is treated as full width.
- `ram_addr_o` is the low `MEM_ADDR_W` bits of the word address. The word address wraps modulo 2^`MEM_ADDR_W` and never saturates.
- All RESP outputs default to OKAY (00).

## Timing
- Reset values: all `*ready_o`, `*valid_o`, `ram_en_o`, `ram_we_o`, `rlast`, `bresp`, and `rresp` are 0.
- Asserting reset mid-burst aborts immediately (asynchronously) to IDLE. No response is issued.
- Write: AW handshake at cycle T. `wready` is high from T+1, giving 1 beat/cycle. `bvalid` goes high the cycle after the final W beat.
- Read: AR handshake at cycle T. `rvalid` is high at T+2. After an `rready` handshake at T', the next `rvalid` is at T'+2, giving 1 beat per 2 cycles.
- `valid` is never withdrawn before its handshake. `rdata`, `rresp`, and `rlast` stay stable under backpressure.
- AW and AR are not accepted outside IDLE. A new transaction can be accepted in the cycle after a B or last-R handshake.

## Configuration
- `IOB_AXI_RAM_RESP_BOUNDS_EN` defined: each beat is checked for word address ≥ `MEM_WORDS`.
  - Write beat out of range: `ram_en_o` is suppressed for that beat. `bresp`=SLVERR (10) if any beat of the burst was out of range.
  - Read beat out of range: no RAM access. `rdata`=0 and `rresp`=SLVERR for that beat only.
- Macro undefined: no check is made. The address wraps as described in Operation and every response is OKAY.

## Test plan
- Single write then read: AW addr 0x10, len 0, data 0xDEADBEEF, strb F → B OKAY. AR addr 0x10 returns 0xDEADBEEF with `rlast`=1, `rvalid` at AR+2.
- 16-beat INCR burst: write addr 0x100, data i at beat i, strb 0x3 on beat 5 → read back gives i everywhere except beat 5, whose upper halfword keeps its old value. `rlast` is high only on beat 15.
- Read backpressure: `rready` low for 5 cycles on beat 2 → `rvalid`/`rdata` are held and no extra RAM access occurs.
- Simultaneous `awvalid` and `arvalid`, twice back-to-back → write is granted first, then read. After that, repeated ties alternate.
- FIXED write of 4 beats to 0x40 → `ram_addr_o`=0x10 on every beat and the final word holds beat 3's data.
- With `IOB_AXI_RAM_RESP_BOUNDS_EN`, 2-beat read from word 3071 → beat 0 OKAY with RAM data, beat 1 SLVERR with data 0. Without the macro, the same burst is all OKAY and the address continues to 3072.
